mips32_prog_loader: RTL and testbench
=====================================

# mips32_prog_loader

Boot-time program loader sitting directly upstream of the MIPS32 pipelined core's instruction memory. Receives a byte stream (header, instruction words, optional checksum) over a valid/ready interface, assembles big-endian 32-bit words, and writes them into instruction memory. When loading completes it releases the core with a one-cycle start pulse, replacing direct memory preloading.

## Interface
- `IM_AW`, 10, instruction-memory word-address width.
- `BASE_ADDR`, 0, first instruction-memory word address written; addresses wrap modulo 2^IM_AW.
- `clk1`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  `rx_data` holds a byte.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte this cycle; transfer = `rx_valid & rx_ready` at the edge.
- `im_we`  out  1  instruction-memory write strobe, one cycle per word.
- `im_addr`  out  IM_AW  write word address.
- `im_wdata`  out  32  write data.
- `cpu_start`  out  1  one-cycle pulse: core clears PC, HALTED, TAKEN_BRANCH.
- `cpu_run`  out  1  level; core may fetch only while high.
- `cpu_halted`  in  1  core has retired HLT.
- `err`  out  1  checksum failure, sticky.

## Operation
- Stream format: header byte N (word count, 1..255), then 4·N payload bytes, first byte → `im_wdata[31:24]`; with `LOADER_CHECKSUM_EN`, one trailing checksum byte.
- States: IDLE, LOAD, CHK (macro only), START, RUN, ERR.
- IDLE: `rx_ready`=1. Header 0 is discarded, stay IDLE. Nonzero header: latch N, word index=0, byte phase=0, → LOAD.
- LOAD: `rx_ready`=1. Each accepted byte shifts into the word register; on the 4th byte, word is registered for write, index increments. After word N: → CHK (macro) or → START.
- Write address = (BASE_ADDR + index) mod 2^IM_AW; N > 2^IM_AW overwrites wrapped locations, no error.
- CHK: `rx_ready`=1. Accepted byte compared with 8-bit sum mod 256 of all 4·N payload bytes (header excluded). Match → START; mismatch → ERR.
- START: `rx_ready`=0, `cpu_start`=1 for exactly this cycle → RUN.
- RUN: `cpu_run`=1, `rx_ready`=0. `cpu_halted`=1 sampled → IDLE, `cpu_run` low from that edge.
- ERR: `err`=1, `rx_ready`=0, `cpu_run`=0, no exit except reset.
- `rx_valid` gaps are allowed anywhere; no byte is consumed without the handshake.

## Timing
- Reset (async assert): state IDLE, all counters 0; `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_start`=0, `cpu_run`=0, `err`=0, `rx_ready`=0 while `rst_n` low, 1 from deassertion (IDLE decode).
- Write latency: `im_we`=1 the cycle after the edge accepting the 4th byte; `im_addr`/`im_wdata` valid that same cycle, held until next write.
- Back-to-back bytes: one word per 4 cycles; a next-word byte may be accepted during the `im_we` cycle.
- Without macro: `cpu_start` in the cycle after the last `im_we`; `cpu_run`=1 the cycle after that.
- With macro: `cpu_start` the cycle after checksum acceptance.
- Reset mid-load: load aborted, already-written words remain in memory, next load restarts at BASE_ADDR.

## Configuration
- `LOADER_CHECKSUM_EN` defined: CHK state, trailing checksum byte required, `err` functional.
- Not defined: no CHK state, no checksum byte expected, `err` tied 0, ERR unreachable.

## Test plan
- Header 03, bytes 28 01 00 78 / 0c 63 18 00 / fc 00 00 00 → `im_we` at addrs 0,1,2 with 28010078, 0c631800, fc000000; `cpu_start` one cycle, then `cpu_run`=1.
- Header 00 then 01 + 20220000 → first header ignored, single write 20220000 at addr 0, start follows.
- Random `rx_valid` gaps (0–5 cycles) over 8-word load → exactly 8 writes, data identical to gap-free run.
- RUN, raise `cpu_halted` → `cpu_run`=0 next edge, IDLE; second program header 01 + 2842002d loads at addr 0 and restarts.
- Macro on: correct checksum → start; checksum off by 1 → `err`=1, no `cpu_start`, `rx_ready`=0 until reset.
- BASE_ADDR=1023, IM_AW=10, 2 words → addrs 1023 then 0; separately reset after 2 payload bytes → all outputs reset, new load writes addr BASE_ADDR correctly.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader
//
// Boot-time program loader for the MIPS32 pipelined core. A byte stream
// arrives over a valid/ready port: a header byte N (word count, 1..255),
// then 4*N payload bytes (big-endian words, first byte -> bits 31:24) and,
// when LOADER_CHECKSUM_EN is defined, one trailing checksum byte. It is the
// 8-bit sum of all payload bytes. Each assembled word is written into
// instruction memory at (BASE_ADDR + index) mod 2^IM_AW. After the last
// word (and the checksum, if enabled) the core is released with a
// one-cycle cpu_start pulse. cpu_run is then held until the core reports
// cpu_halted.
//
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHK state, the
// trailing checksum byte and a functional, sticky err output).
//
// Handshake: a byte moves when rx_valid and rx_ready are both high at a
// rising edge of clk1. rx_ready depends only on loader state and rst_n,
// never on rx_valid. A source may insert rx_valid gaps at any point.
//
// Ports:
//   clk1        in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rx_valid    in   rx_data holds a byte
//   rx_data     in   [7:0] stream byte
//   rx_ready    out  loader accepts a byte this cycle
//   im_we       out  instruction-memory write strobe, one cycle per word
//   im_addr     out  [IM_AW-1:0] write word address
//   im_wdata    out  [31:0] write data
//   cpu_start   out  one-cycle core release pulse
//   cpu_run     out  core may fetch while high
//   cpu_halted  in   core has retired HLT
//   err         out  checksum failure, sticky until reset
//   dbg_state   out  [2:0] current FSM state, for observation only
module mips32_prog_loader #(
    parameter int IM_AW     = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             im_we,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      im_wdata,
    output logic             cpu_start,
    output logic             cpu_run,
    input  logic             cpu_halted,
    output logic             err,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;
`endif

    logic [2:0]       state_q,    state_d;
    logic [7:0]       n_q,        n_d;        // words in this program
    logic [7:0]       idx_q,      idx_d;      // words assembled so far
    logic [1:0]       phase_q,    phase_d;    // byte position within word
    logic [23:0]      word_q,     word_d;     // first three bytes of word
    logic             im_we_q,    im_we_d;
    logic [IM_AW-1:0] im_addr_q,  im_addr_d;
    logic [31:0]      im_wdata_q, im_wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       sum_q,      sum_d;      // running payload byte sum
`endif

    logic             load_done;
    logic             accept;
    logic [IM_AW-1:0] wr_addr;

    // All N words assembled. LOAD spends one more cycle here, with
    // rx_ready low, so that the release step follows the final im_we cycle.
    assign load_done = (idx_q == n_q);

    always_comb begin
        rx_ready = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IDLE:  rx_ready = 1'b1;
                S_LOAD:  rx_ready = !load_done;
`ifdef LOADER_CHECKSUM_EN
                S_CHK:   rx_ready = 1'b1;
`endif
                default: rx_ready = 1'b0;
            endcase
        end
    end

    assign accept  = rx_valid && rx_ready;
    // The cast truncates the sum, which gives the modulo 2^IM_AW wrap.
    assign wr_addr = IM_AW'(BASE_ADDR) + IM_AW'(idx_q);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        word_d     = word_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A zero header is consumed and ignored.
                if (accept && (rx_data != 8'd0)) begin
                    n_d     = rx_data;
                    idx_d   = 8'd0;
                    phase_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_done) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_START;
`endif
                end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + rx_data;
`endif
                    if (phase_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_addr_d  = wr_addr;
                        im_wdata_d = {word_q, rx_data};
                        idx_d      = idx_q + 8'd1;
                        phase_d    = 2'd0;
                    end else begin
                        word_d  = {word_q[15:0], rx_data};
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d = (rx_data == sum_q) ? S_START : S_ERR;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
`endif
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cpu_halted) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= 8'd0;
            idx_q      <= 8'd0;
            phase_q    <= 2'd0;
            word_q     <= 24'd0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            word_q     <= word_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;
    assign cpu_start = (state_q == S_START);
    assign cpu_run   = (state_q == S_RUN);
    assign dbg_state = state_q;
`ifdef LOADER_CHECKSUM_EN
    assign err       = (state_q == S_ERR);
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Testbench for mips32_prog_loader. Two instances share every input: dut0
// uses BASE_ADDR=0 and dut1 uses BASE_ADDR=1023, so each load also tests
// address wrap. The expected memory writes come from the program word list
// and the address rule (base + i) mod 1024.
module tb_mips32_prog_loader;

    localparam int AW = 10;
    localparam int W  = AW + 32;

    logic          clk1 = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          cpu_halted = 1'b0;

    logic          rx_ready0, im_we0, cpu_start0, cpu_run0, err0;
    logic [AW-1:0] im_addr0;
    logic [31:0]   im_wdata0;
    logic [2:0]    dbg0;
    logic          rx_ready1, im_we1, cpu_start1, cpu_run1, err1;
    logic [AW-1:0] im_addr1;
    logic [31:0]   im_wdata1;
    logic [2:0]    dbg1;

    mips32_prog_loader #(.IM_AW(AW), .BASE_ADDR(0)) dut0 (
        .clk1(clk1), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready0), .im_we(im_we0), .im_addr(im_addr0),
        .im_wdata(im_wdata0), .cpu_start(cpu_start0), .cpu_run(cpu_run0),
        .cpu_halted(cpu_halted), .err(err0), .dbg_state(dbg0)
    );

    mips32_prog_loader #(.IM_AW(AW), .BASE_ADDR(1023)) dut1 (
        .clk1(clk1), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready1), .im_we(im_we1), .im_addr(im_addr1),
        .im_wdata(im_wdata1), .cpu_start(cpu_start1), .cpu_run(cpu_run1),
        .cpu_halted(cpu_halted), .err(err1), .dbg_state(dbg1)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  prog_q[$];
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];
    logic [W-1:0] got0_q[$];
    logic [W-1:0] got1_q[$];
    int           lat_q[$];
    int           wecyc_q[$];
    int           last_acc  = 0;
    int           last_we   = 0;
    int           start_cyc = 0;
    int           n_start   = 0;

    // Monitor: sampled on the falling edge. The write is handled before the
    // handshake, so a write's latency refers to the byte that completed it.
    always @(negedge clk1) begin
        if (im_we0) begin
            got0_q.push_back({im_addr0, im_wdata0});
            lat_q.push_back(cyc - last_acc);
            wecyc_q.push_back(cyc);
            last_we = cyc;
        end
        if (im_we1) got1_q.push_back({im_addr1, im_wdata1});
        if (cpu_start0) begin
            n_start++;
            start_cyc = cyc;
        end
        if (rx_valid && rx_ready0) last_acc = cyc;
    end

    task automatic clear_sb();
        exp0_q.delete(); exp1_q.delete();
        got0_q.delete(); got1_q.delete();
        lat_q.delete();  wecyc_q.delete();
        n_start = 0;
    endtask

    // Reference model: word i goes to (base + i) mod 2^AW.
    task automatic build_expect();
        foreach (prog_q[i]) begin
            exp0_q.push_back({AW'((0 + i) % (1 << AW)), prog_q[i]});
            exp1_q.push_back({AW'((1023 + i) % (1 << AW)), prog_q[i]});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        repeat (gap) begin
            rx_valid = 1'b0;
            @(posedge clk1); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        budget   = 0;
        while (!rx_ready0 && budget < 100) begin
            @(posedge clk1); #1;
            budget++;
        end
        if (budget >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL send_byte_timeout: rx_ready=%0b, required 1 within 100 cycles", rx_ready0);
        end
        @(posedge clk1); #1;
    endtask

    task automatic send_payload(input int gapmax);
        send_byte(8'(prog_q.size()), $urandom_range(0, gapmax));
        foreach (prog_q[i]) begin
            for (int k = 3; k >= 0; k--) begin
                send_byte(prog_q[i][k*8 +: 8], $urandom_range(0, gapmax));
            end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    function automatic logic [7:0] prog_sum();
        logic [7:0] s;
        s = 8'd0;
        foreach (prog_q[i]) s = s + prog_q[i][31:24] + prog_q[i][23:16] + prog_q[i][15:8] + prog_q[i][7:0];
        return s;
    endfunction
`endif

    task automatic send_program(input int gapmax);
        send_payload(gapmax);
`ifdef LOADER_CHECKSUM_EN
        send_byte(prog_sum(), $urandom_range(0, gapmax));
`endif
        rx_valid = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic score(input string name, input int b2b);
        int budget;
        budget = 0;
        while (n_start == 0 && budget < 2000) begin
            @(negedge clk1); #1;
            budget++;
        end
        n_checks++;
        if (n_start != 1) begin
            n_fail++;
            $display("FAIL %s start_count: got %0d, required 1", name, n_start);
        end
        n_checks++;
        if (cpu_start0 !== 1'b1 || cpu_run0 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_cycle: cpu_start=%0b cpu_run=%0b, required 1/0", name, cpu_start0, cpu_run0);
        end
        n_checks++;
`ifdef LOADER_CHECKSUM_EN
        if (start_cyc != last_acc + 1) begin
            n_fail++;
            $display("FAIL %s start_timing: start cycle %0d, required %0d", name, start_cyc, last_acc + 1);
        end
`else
        if (start_cyc != last_we + 1) begin
            n_fail++;
            $display("FAIL %s start_timing: start cycle %0d, required %0d", name, start_cyc, last_we + 1);
        end
`endif
        @(negedge clk1); #1;
        n_checks++;
        if (cpu_start0 !== 1'b0 || cpu_run0 !== 1'b1 || rx_ready0 !== 1'b0 || cpu_run1 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s run_level: start=%0b run=%0b ready=%0b run1=%0b, required 0/1/0/1",
                     name, cpu_start0, cpu_run0, rx_ready0, cpu_run1);
        end
        n_checks++;
        if (got0_q.size() != exp0_q.size() || got1_q.size() != exp1_q.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d/%0d, required %0d/%0d",
                     name, got0_q.size(), got1_q.size(), exp0_q.size(), exp1_q.size());
        end else begin
            foreach (exp0_q[i]) begin
                n_checks++;
                if (got0_q[i] !== exp0_q[i] || got1_q[i] !== exp1_q[i]) begin
                    n_fail++;
                    $display("FAIL %s write[%0d]: got %h/%h, required %h/%h",
                             name, i, got0_q[i], got1_q[i], exp0_q[i], exp1_q[i]);
                end
                n_checks++;
                if (lat_q[i] != 1) begin
                    n_fail++;
                    $display("FAIL %s write_latency[%0d]: got %0d, required 1", name, i, lat_q[i]);
                end
                if (b2b != 0 && i > 0) begin
                    n_checks++;
                    if (wecyc_q[i] - wecyc_q[i-1] != 4) begin
                        n_fail++;
                        $display("FAIL %s word_spacing[%0d]: got %0d, required 4",
                                 name, i, wecyc_q[i] - wecyc_q[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic run_halt(input string name);
        @(posedge clk1); #1;
        cpu_halted = 1'b1;
        @(posedge clk1); #1;
        cpu_halted = 1'b0;
        n_checks++;
        if (cpu_run0 !== 1'b0 || rx_ready0 !== 1'b1 || cpu_start0 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s halt: run=%0b ready=%0b start=%0b, required 0/1/0", name, cpu_run0, rx_ready0, cpu_start0);
        end
        n_checks++;
        if ({rx_ready1, cpu_run1, cpu_start1, err1, dbg1} !== {rx_ready0, cpu_run0, cpu_start0, err0, dbg0}) begin
            n_fail++;
            $display("FAIL %s lockstep: dut1 %b, required %b", name,
                     {rx_ready1, cpu_run1, cpu_start1, err1, dbg1}, {rx_ready0, cpu_run0, cpu_start0, err0, dbg0});
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk1); #1;
        n_checks++;
        if ({im_we0, im_addr0, im_wdata0, cpu_start0, cpu_run0, err0, rx_ready0} !== '0 || im_addr1 !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%0b addr=%h data=%h start=%0b run=%0b err=%0b ready=%0b, required all 0",
                     im_we0, im_addr0, im_wdata0, cpu_start0, cpu_run0, err0, rx_ready0);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rx_ready0 !== 1'b1 || rx_ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b/%0b, required 1/1", rx_ready0, rx_ready1);
        end
        @(posedge clk1); #1;
    endtask

    task automatic test_basic();
        clear_sb();
        prog_q = '{32'h28010078, 32'h0c631800, 32'hfc000000};
        build_expect();
        send_program(0);
        score("basic", 1);
        run_halt("basic");
    endtask

    task automatic test_zero_header();
        clear_sb();
        send_byte(8'h00, 0);
        rx_valid = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
        n_checks++;
        if (rx_ready0 !== 1'b1 || got0_q.size() != 0 || cpu_run0 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_header_idle: ready=%0b writes=%0d run=%0b, required 1/0/0", rx_ready0, got0_q.size(), cpu_run0);
        end
        prog_q = '{32'h20220000};
        build_expect();
        send_program(0);
        score("zero_header", 0);
        run_halt("zero_header");
    endtask

    task automatic test_gaps();
        clear_sb();
        prog_q.delete();
        for (int i = 0; i < 8; i++) prog_q.push_back($urandom);
        build_expect();
        send_program(5);
        score("gaps", 0);
        run_halt("gaps");
    endtask

    task automatic test_halt_reload();
        clear_sb();
        prog_q = '{32'h2842002d};
        build_expect();
        send_program(1);
        score("halt_reload", 0);
        run_halt("halt_reload");
    endtask

    task automatic test_back_to_back();
        clear_sb();
        prog_q.delete();
        for (int i = 0; i < 5; i++) prog_q.push_back($urandom);
        build_expect();
        send_program(0);
        score("back_to_back", 1);
        run_halt("back_to_back");
    endtask

    task automatic test_wrap();
        clear_sb();
        prog_q = '{$urandom, $urandom};
        build_expect();
        send_program(2);
        score("wrap", 0);
        n_checks++;
        if (got1_q.size() != 2 || got1_q[0][W-1:32] !== 10'd1023 || got1_q[1][W-1:32] !== 10'd0) begin
            n_fail++;
            $display("FAIL wrap_addrs: got %0d writes, required addrs 1023 then 0", got1_q.size());
        end
        run_halt("wrap");
    endtask

    task automatic test_reset_mid();
        clear_sb();
        send_byte(8'h02, 0);
        send_byte(8'haa, 0);
        send_byte(8'hbb, 0);
        rx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({im_we0, im_addr0, im_wdata0, cpu_start0, cpu_run0, err0, rx_ready0, rx_ready1} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: we=%0b addr=%h data=%h start=%0b run=%0b err=%0b ready=%0b, required all 0",
                     im_we0, im_addr0, im_wdata0, cpu_start0, cpu_run0, err0, rx_ready0);
        end
        @(posedge clk1); #1;
        rst_n = 1'b1;
        @(posedge clk1); #1;
        clear_sb();
        prog_q = '{$urandom};
        build_expect();
        send_program(0);
        score("reset_mid", 0);
        run_halt("reset_mid");
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_sb();
        prog_q = '{$urandom, $urandom, $urandom};
        build_expect();
        send_program(1);
        score("checksum_good", 0);
        run_halt("checksum_good");
        clear_sb();
        prog_q = '{$urandom, $urandom};
        send_payload(1);
        send_byte(prog_sum() + 8'd1, 0);
        rx_valid = 1'b0;
        repeat (10) @(posedge clk1);
        #1;
        n_checks++;
        if (err0 !== 1'b1 || n_start != 0 || rx_ready0 !== 1'b0 || cpu_run0 !== 1'b0) begin
            n_fail++;
            $display("FAIL checksum_bad: err=%0b starts=%0d ready=%0b run=%0b, required 1/0/0/0",
                     err0, n_start, rx_ready0, cpu_run0);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (err0 !== 1'b0) begin
            n_fail++;
            $display("FAIL checksum_err_reset: err=%0b, required 0", err0);
        end
        @(posedge clk1); #1;
        rst_n = 1'b1;
        @(posedge clk1); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_header();
        test_gaps();
        test_halt_reload();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
